// File: rtl/mc_control.sv
// Multi-cycle instruction sequencer: owns the instruction register, arbitrates the shared
// memory port through a req/ready handshake and drives the datapath strobes.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | post-reset bubble, no strobes
// S_FETCH  | instruction read from PC, IR and PC+4 loaded on mem_ready
// S_DECODE | IR fields settle, illegal encodings trapped
// S_EXEC   | ALU operation; branches and jumps finish here
// S_MEM    | data access for lw/sw at the ALU address
// S_WB     | register file write-back
// S_FAULT  | sticky error, left only through rst_n
module mc_control #(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_sel,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic [1:0]         wb_src,
  output logic [1:0]         alu_src,
  output logic [2:0]         alu_op,
  output logic [REG_AW-1:0]  addr_a,
  output logic [REG_AW-1:0]  addr_b,
  output logic [REG_AW-1:0]  addr_in,
  output logic [REG_AW-1:0]  shamt,
  output logic [15:0]        imm16,
  output logic [25:0]        addr26,
  output logic               retire,
  output logic               fault
);

  localparam logic [1:0] ALU_SRC_REG        = 2'd0;
  localparam logic [1:0] ALU_SRC_SEXT_IMM16 = 2'd1;
  localparam logic [1:0] ALU_SRC_ZEXT_IMM16 = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  // Terminal count of the wait counter; a zero TIMEOUT never hits it.
  localparam logic [CNT_W-1:0] WAIT_TC = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timeout_hit;

  logic [5:0] opcode, funct;
  logic       legal, is_rtype, is_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
  logic [2:0] dec_op;
  logic [1:0] dec_src;

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign is_rtype = (opcode == 6'h00);

  assign addr_a  = REG_AW'(ir[25:21]);
  assign addr_b  = REG_AW'(ir[20:16]);
  assign shamt   = REG_AW'(ir[10:6]);
  assign imm16   = ir[15:0];
  assign addr26  = ir[25:0];
  assign addr_in = is_jal ? {REG_AW{1'b1}} : (is_rtype ? REG_AW'(ir[15:11]) : REG_AW'(ir[20:16]));
  assign alu_op  = dec_op;
  assign alu_src = dec_src;

  always_comb begin
    legal   = 1'b0;
    is_alu  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    dec_op  = OP_ADD;
    dec_src = ALU_SRC_REG;
    case (opcode)
      6'h00: begin
        legal  = 1'b1;
        is_alu = 1'b1;
        case (funct)
          6'h20: dec_op = OP_ADD;
          6'h22: dec_op = OP_SUB;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h27: dec_op = OP_NOR;
          6'h2A: dec_op = OP_SLT;
          6'h00: dec_op = OP_SLL;
          6'h02: dec_op = OP_SRL;
          6'h08: begin
            is_alu = 1'b0;
            is_jr  = 1'b1;
          end
          default: begin
            legal  = 1'b0;
            is_alu = 1'b0;
          end
        endcase
      end
      6'h08: begin legal = 1'b1; is_alu = 1'b1; dec_src = ALU_SRC_SEXT_IMM16; end
      6'h0C: begin legal = 1'b1; is_alu = 1'b1; dec_op = OP_AND; dec_src = ALU_SRC_ZEXT_IMM16; end
      6'h0D: begin legal = 1'b1; is_alu = 1'b1; dec_op = OP_OR;  dec_src = ALU_SRC_ZEXT_IMM16; end
      6'h23: begin legal = 1'b1; is_lw = 1'b1; dec_src = ALU_SRC_SEXT_IMM16; end
      6'h2B: begin legal = 1'b1; is_sw = 1'b1; dec_src = ALU_SRC_SEXT_IMM16; end
      6'h04: begin legal = 1'b1; is_beq = 1'b1; dec_op = OP_SUB; end
      6'h05: begin legal = 1'b1; is_bne = 1'b1; dec_op = OP_SUB; end
      6'h02: begin legal = 1'b1; is_j = 1'b1; end
      6'h03: begin legal = 1'b1; is_jal = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (ir_write) begin
      ir <= mem_rdata;
    end
  end

  // Counts consecutive not-ready cycles of one access; any other cycle clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if ((state == S_FETCH || state == S_MEM) && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    reg_write = 1'b0;
    wb_src    = WB_ALU;
    retire    = 1'b0;
    fault     = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout_hit) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: state_nxt = legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        if (is_alu) begin
          state_nxt = S_WB;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else if (is_beq || is_bne) begin
          pc_src    = PC_BRANCH;
          pc_write  = is_beq ? alu_zero : !alu_zero;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_j || is_jal) begin
          pc_src    = PC_JUMP;
          pc_write  = 1'b1;
          reg_write = is_jal;
          wb_src    = is_jal ? WB_LINK : WB_ALU;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_jr) begin
          pc_src    = PC_RS;
          pc_write  = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_FAULT;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          retire    = is_sw;
          state_nxt = is_sw ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          state_nxt = S_FAULT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_src    = is_lw ? WB_MEM : WB_ALU;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus queues the expected strobe pattern for each
// active cycle, a negedge monitor pops and compares whenever the DUT shows any activity.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_ready, alu_zero;
  logic        mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write, retire, fault;
  logic [1:0]  pc_src, wb_src, alu_src;
  logic [2:0]  alu_op;
  logic [4:0]  addr_a, addr_b, addr_in, shamt;
  logic [15:0] imm16;
  logic [25:0] addr26;

  mc_control #(.INSTR_W(32), .REG_AW(5), .TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_src(wb_src),
    .alu_src(alu_src), .alu_op(alu_op), .addr_a(addr_a), .addr_b(addr_b), .addr_in(addr_in),
    .shamt(shamt), .imm16(imm16), .addr26(addr26), .retire(retire), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          cyc;
    logic [11:0] ctl;
    logic [35:0] fld;
    logic [35:0] msk;
  } exp_t;

  localparam logic [35:0] M_ALL   = 36'hF_FFFF_FFFF;
  localparam logic [35:0] M_NOSRC = 36'hF_9FFF_FFFF;
  localparam logic [35:0] M_NOALU = 36'hF_83FF_FFFF;
  localparam logic [35:0] M_IMM   = 36'h0_0000_FFFF;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [11:0] act_ctl;
  logic [35:0] act_fld;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc_n = 0;
  bit          mon_on = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [11:0] ctl_v(input logic req, we, sel, irw, pcw, input logic [1:0] pcs,
                                        input logic rw, input logic [1:0] wb, input logic ret, flt);
    return {req, we, sel, irw, pcw, pcs, rw, wb, ret, flt};
  endfunction

  function automatic logic [35:0] fld_v(input logic [4:0] ain, input logic [1:0] src,
                                        input logic [2:0] op, input logic [4:0] a, b,
                                        input logic [15:0] imm);
    return {ain, src, op, a, b, imm};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_now(input string tag, input logic [11:0] ctl, input logic [35:0] fld,
                            input logic [35:0] msk);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc_n;
    e.ctl = ctl;
    e.fld = fld;
    e.msk = msk;
    sb.push_back(e);
  endtask

  // Applies inputs for the current cycle, then advances to 2ns past the next rising edge.
  task automatic step(input logic r, input logic [31:0] d, input logic z);
    mem_ready = r;
    mem_rdata = d;
    alu_zero  = z;
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] instr);
    expect_now("fetch", ctl_v(1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 0, 0), '0, '0);
    step(1'b1, instr, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      act_ctl = {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg_write, wb_src,
                 retire, fault};
      act_fld = {addr_in, alu_src, alu_op, addr_a, addr_b, imm16};
      if (act_ctl != '0) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_activity: cyc %0d got ctl %b expected no activity",
                   cyc_n, act_ctl);
        end else begin
          mon_e = sb.pop_front();
          if (act_ctl === mon_e.ctl && cyc_n == mon_e.cyc &&
              (act_fld & mon_e.msk) === (mon_e.fld & mon_e.msk))
            n_pass++;
          else
            $display("FAIL %s: got cyc %0d ctl %b fld %h, expected cyc %0d ctl %b fld %h",
                     mon_e.tag, cyc_n, act_ctl, act_fld & mon_e.msk, mon_e.cyc, mon_e.ctl,
                     mon_e.fld & mon_e.msk);
        end
      end
    end
  end

  initial begin
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    alu_zero  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_strobes", {mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write}, '0);
    chk("rst_retire_fault", {retire, fault}, '0);
    chk("rst_ir_fields", {addr_a, addr_b, addr_in, imm16}, '0);

    rst_n  = 1'b1;
    mon_on = 1'b1;
    step(1, 0, 0);                                   // IDLE

    fetch(32'h2010FEFE);                             // addi $s0,$zero,0xFEFE
    step(1, 0, 0);
    step(1, 0, 0);
    expect_now("addi_wb", ctl_v(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 1, 0),
               fld_v(5'd16, 2'd1, 3'd0, 5'd0, 5'd16, 16'hFEFE), M_ALL);
    step(1, 0, 0);

    fetch(32'h8E080004);                             // lw $t0,4($s0)
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (3) begin
      expect_now("lw_mem_wait", ctl_v(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0),
                 fld_v(5'd8, 2'd1, 3'd0, 5'd16, 5'd8, 16'h0004), M_ALL);
      step(0, 0, 0);
    end
    expect_now("lw_mem_done", ctl_v(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0),
               fld_v(5'd8, 2'd1, 3'd0, 5'd16, 5'd8, 16'h0004), M_ALL);
    step(1, 0, 0);
    expect_now("lw_wb", ctl_v(0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 1, 0),
               fld_v(5'd8, 2'd1, 3'd0, 5'd16, 5'd8, 16'h0004), M_ALL);
    step(0, 0, 0);

    fetch(32'h1520FFFD);                             // bne, taken
    step(0, 0, 0);
    expect_now("bne_taken", ctl_v(0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 1, 0),
               fld_v(5'd0, 2'd0, 3'd1, 5'd9, 5'd0, 16'hFFFD), M_NOSRC);
    step(0, 0, 0);
    fetch(32'h1520FFFD);                             // bne, not taken
    step(0, 0, 1);
    expect_now("bne_not_taken", ctl_v(0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 1, 0),
               fld_v(5'd0, 2'd0, 3'd1, 5'd9, 5'd0, 16'hFFFD), M_NOSRC);
    step(0, 0, 1);

    fetch(32'h360900F0);                             // ori $t1,$s0,0x00F0
    step(0, 0, 0);
    step(0, 0, 0);
    expect_now("ori_wb", ctl_v(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 1, 0),
               fld_v(5'd9, 2'd2, 3'd3, 5'd16, 5'd9, 16'h00F0), M_ALL);
    step(0, 0, 0);

    fetch(32'h02095020);                             // add $t2,$s0,$t1
    step(0, 0, 0);
    step(0, 0, 0);
    expect_now("add_wb", ctl_v(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 1, 0),
               fld_v(5'd10, 2'd0, 3'd0, 5'd16, 5'd9, 16'h5020), M_ALL);
    step(0, 0, 0);

    fetch(32'h0C000010);                             // jal
    step(0, 0, 0);
    expect_now("jal_exec", ctl_v(0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 1, 0),
               fld_v(5'd31, 2'd0, 3'd0, 5'd0, 5'd0, 16'h0010), M_NOALU);
    step(0, 0, 0);

    fetch(32'h03E00008);                             // jr $ra
    step(0, 0, 0);
    expect_now("jr_exec", ctl_v(0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 1, 0),
               fld_v(5'd0, 2'd0, 3'd0, 5'd31, 5'd0, 16'h0008), M_NOALU);
    step(0, 0, 0);

    fetch(32'h08000020);                             // j
    step(0, 0, 0);
    expect_now("j_exec", ctl_v(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 1, 0),
               fld_v(5'd0, 2'd0, 3'd0, 5'd0, 5'd0, 16'h0020), M_IMM);
    step(0, 0, 0);

    fetch(32'hAE080008);                             // sw $t0,8($s0), no wait
    step(0, 0, 0);
    step(0, 0, 0);
    expect_now("sw_mem", ctl_v(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 1, 0),
               fld_v(5'd8, 2'd1, 3'd0, 5'd16, 5'd8, 16'h0008), M_ALL);
    step(1, 0, 0);

    fetch(32'hAE080008);                             // sw, reset during wait
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (2) begin
      expect_now("sw_mem_wait", ctl_v(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0),
                 fld_v(5'd8, 2'd1, 3'd0, 5'd16, 5'd8, 16'h0008), M_ALL);
      step(0, 0, 0);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_drops_req", mem_req, 1'b0);
    chk("rst_drops_we", mem_we, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", {mem_req, ir_write, pc_write, fault}, '0);
    step(0, 0, 0);                                   // IDLE

    fetch(32'hFC000000);                             // illegal opcode 0x3F
    step(1, 0, 0);                                   // DECODE
    for (int i = 0; i < 4; i++) begin
      expect_now("illegal_fault", ctl_v(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1), '0, '0);
      step(1'(i % 2), 32'h2010FEFE, 1'(i % 2));
    end

    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(0, 0, 0);                                   // IDLE
    repeat (4) begin
      expect_now("timeout_wait", ctl_v(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0), '0, '0);
      step(0, 32'h2010FEFE, 0);
    end
    expect_now("timeout_fault", ctl_v(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1), '0, '0);
    step(0, 32'h2010FEFE, 0);
    for (int i = 0; i < 4; i++) begin
      expect_now("fault_sticky", ctl_v(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1), '0, '0);
      step(1'(i % 2 == 0), 32'h2010FEFE, 1'b1);
    end
    mon_on = 1'b0;

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("fault_held_end", {fault, mem_req}, 2'b10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
